// File: rtl/rtype_pkg.sv
// rtype_pkg: shared encodings and the instruction-to-ALU-op decoder for the R-type stage.
package rtype_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT = 7'h20;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR = 3'b101;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, ILLEGAL} alu_op_e;
  // An unknown opcode fails the equality test, so X words fall through to ILLEGAL.
  function automatic alu_op_e decode(input logic [XLEN-1:0] ir);
    decode = ILLEGAL;
    if (ir[6:0] == OPC_RTYPE)
      case ({ir[31:25], ir[14:12]})
        {F7_BASE, F3_ADD_SUB}: decode = ADD;
        {F7_ALT, F3_ADD_SUB}:  decode = SUB;
        {F7_BASE, F3_SLL}:     decode = SLL;
        {F7_BASE, F3_SLT}:     decode = SLT;
        {F7_BASE, F3_SLTU}:    decode = SLTU;
        {F7_BASE, F3_XOR}:     decode = XOR;
        {F7_BASE, F3_SR}:      decode = SRL;
        {F7_ALT, F3_SR}:       decode = SRA;
        {F7_BASE, F3_OR}:      decode = OR;
        {F7_BASE, F3_AND}:     decode = AND;
        default:               decode = ILLEGAL;
      endcase
  endfunction
endpackage

// File: rtl/rtype_alu.sv
// rtype_alu: combinational RV32I R-type ALU; ILLEGAL yields zero.
module rtype_alu
  import rtype_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ADD:     y = a + b;
      SUB:     y = a - b;
      SLL:     y = a << b[4:0];
      SLT:     y = {31'b0, $signed(a) < $signed(b)};
      SLTU:    y = {31'b0, a < b};
      XOR:     y = a ^ b;
      SRL:     y = a >> b[4:0];
      SRA:     y = $unsigned($signed(a) >>> b[4:0]);
      OR:      y = a | b;
      AND:     y = a & b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/rtype_decoder.sv
// rtype_decoder: 4-phase R-type decode/execute stage with a 32x32 register file.
// Phase 1 captures IR, 2 reads operands, 3 computes, 0 writes back.
module rtype_decoder
  import rtype_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] res,
  output logic [XLEN-1:0] wrt
);
  logic [1:0] phase_q;
  logic [XLEN-1:0] ir_q, op1_q, op2_q, res_q, wrt_q, y;
  logic [XLEN-1:0] x_q [NREGS];
  logic [4:0] rs1, rs2, rd;
  alu_op_e op;
  logic we;
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd = ir_q[11:7];
  assign op = decode(ir_q);
  assign we = (op != ILLEGAL) && (rd != 5'd0);
  rtype_alu u_alu (.a(op1_q), .b(op2_q), .op(op), .y(y));
  // IR holds from phase 1 to the next phase 1, so decode stays valid through writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      ir_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      res_q <= '0;
      wrt_q <= '0;
      for (int i = 0; i < NREGS; i++) x_q[i] <= XLEN'(i);
    end else begin
      phase_q <= phase_q + 2'd1;
      case (phase_q)
        2'd1: ir_q <= instruction;
        2'd2: begin
          op1_q <= (rs1 == 5'd0) ? '0 : x_q[rs1];
          op2_q <= (rs2 == 5'd0) ? '0 : x_q[rs2];
        end
        2'd3: res_q <= y;
        default: begin
          wrt_q <= we ? res_q : '0;
          if (we) x_q[rd] <= res_q;
        end
      endcase
    end
  end
  assign op1 = op1_q;
  assign op2 = op2_q;
  assign res = res_q;
  assign wrt = wrt_q;
endmodule

// File: tb/tb_rtype_decoder.sv
// tb_rtype_decoder: directed scoreboard bench for the R-type decode/execute stage.
module tb_rtype_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] op1, op2, res, wrt;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string tag;
    logic [31:0] op1, op2, res, wrt;
  } exp_t;
  exp_t sb[$];

  rtype_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .op1(op1), .op2(op2), .res(res), .wrt(wrt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called just after a phase-0 edge: drive the word, run one 4-cycle slot, then score it.
  task automatic slot(input string tag, input logic [31:0] ins,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] er, input logic [31:0] ew);
    exp_t e;
    sb.push_back('{tag, e1, e2, er, ew});
    instruction = ins;
    repeat (4) @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".op1"}, op1, e.op1);
      chk({e.tag, ".op2"}, op2, e.op2);
      chk({e.tag, ".res"}, res, e.res);
      chk({e.tag, ".wrt"}, wrt, e.wrt);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst.op1", op1, 32'h0);
    chk("rst.res", res, 32'h0);
    chk("rst.wrt", wrt, 32'h0);
    release_reset();
    slot("add", 32'h002081B3, 32'd1, 32'd2, 32'd3, 32'd3);
    slot("sub", 32'h407102B3, 32'd2, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFB);
    slot("sra", 32'h4012D333, 32'hFFFFFFFB, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFD);
    slot("slt", 32'h0012A433, 32'hFFFFFFFB, 32'd1, 32'd1, 32'd1);
    slot("sltu", 32'h0012B4B3, 32'hFFFFFFFB, 32'd1, 32'd0, 32'd0);
    slot("add_x0", 32'h00208033, 32'd1, 32'd2, 32'd3, 32'd0);
    slot("rd_x0", 32'h00300533, 32'd0, 32'd3, 32'd3, 32'd3);
    slot("itype", 32'h00000013, 32'd0, 32'd0, 32'd0, 32'd0);
    slot("bad_f7", 32'h7E2081B3, 32'd1, 32'd2, 32'd0, 32'd0);
    slot("bad_sub_f3", 32'h402091B3, 32'd1, 32'd2, 32'd0, 32'd0);
    slot("x3_kept", 32'h000185B3, 32'd3, 32'd0, 32'd3, 32'd3);
    slot("sll", 32'h00231633, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFF4, 32'hFFFFFFF4);
    slot("srl", 32'h002356B3, 32'hFFFFFFFD, 32'd2, 32'h3FFFFFFF, 32'h3FFFFFFF);
    slot("xor", 32'h00334733, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFE);
    slot("or", 32'h0032E7B3, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFB);
    slot("and", 32'h00737833, 32'hFFFFFFFD, 32'd7, 32'd5, 32'd5);
    // add x5,x5,x5 aborted by reset after its compute edge
    instruction = 32'h005282B3;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.res_before", res, 32'hFFFFFFF6);
    rst_n = 1'b0;
    #1;
    chk("abort.op1", op1, 32'h0);
    chk("abort.op2", op2, 32'h0);
    chk("abort.res", res, 32'h0);
    chk("abort.wrt", wrt, 32'h0);
    release_reset();
    slot("after_rst", 32'h006283B3, 32'd5, 32'd6, 32'd11, 32'd11);
    slot("after_rst_x3", 32'h000185B3, 32'd3, 32'd0, 32'd3, 32'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
